// File: rtl/maxpool2x2_stream_if.sv
// ---------------------------------------------------------------------------
// maxpool2x2_stream_if
//   Stream bundle between the conv result producer, the 2x2 max-pool stage
//   and its consumer. The master modport is the side that drives the
//   frame-start pulse and the conv values. The slave modport is the pooling
//   stage.
// ---------------------------------------------------------------------------
interface maxpool2x2_stream_if #(
  parameter int DW = 21,
  parameter int IW = 16
);

  logic                 start;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic [IW-1:0]        out_index;
  logic                 done;

  modport master (
    output start,
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data,
    input  out_index,
    input  done
  );

  modport slave (
    input  start,
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data,
    output out_index,
    output done
  );

endinterface

// File: rtl/maxpool2x2_stream.sv
// ---------------------------------------------------------------------------
// maxpool2x2_stream
//   Streaming 2x2 / stride-2 max-pool stage that sits behind the conv engine.
//   It consumes a raster-order stream of IN_W x IN_H signed values and
//   produces an (IN_W/2) x (IN_H/2) raster stream of window maxima, each
//   tagged with its raster index. There is no backpressure.
//
//   Storage is one register for the left column of the current window
//   (hold) and one line buffer that is half a row wide. On an even row the
//   line buffer stores the pairwise max of the top half of each window. On
//   the following odd row the line buffer entry is combined with the bottom
//   half, and the result is registered out.
//
//   When the input width or height is odd, the trailing column or row is
//   consumed and counted but is never pooled.
//
//   Optional feature (build-time macro):
//     MAXPOOL_RELU_EN - clamp every accepted value to 0 if it is negative
//                       before pooling (fused ReLU). Default: raw signed
//                       pooling.
// ---------------------------------------------------------------------------
module maxpool2x2_stream #(
  parameter int DW   = 21,
  parameter int IN_W = 26,
  parameter int IN_H = 26,
  parameter int IW   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  maxpool2x2_stream_if.slave   bus
);

  // Pooled geometry and counter widths. Each counter must be able to hold
  // its last index, so it is sized for IN_W / IN_H + 1.
  localparam int OW  = IN_W / 2;
  localparam int OH  = IN_H / 2;
  localparam int CW  = $clog2(IN_W + 1);
  localparam int RW  = $clog2(IN_H + 1);
  localparam int LBN = (OW > 0) ? OW : 1;
  localparam int LBW = (OW > 1) ? $clog2(OW) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
  localparam logic [CW-1:0] COL_POOL = CW'(2 * OW);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);
  localparam logic [RW-1:0] ROW_POOL = RW'(2 * OH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Signed maximum over the full data width. There is no truncation or
  // saturation, so the extreme values compare correctly.
  function automatic logic signed [DW-1:0] smax(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  state_t               state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic signed [DW-1:0] hold_q, hold_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [DW-1:0] out_data_q, out_data_d;
  logic [IW-1:0]        out_index_q, out_index_d;
  logic [IW-1:0]        pool_cnt_q, pool_cnt_d;
  logic                 done_q, done_d;

  logic signed [DW-1:0] linebuf_q [LBN];
  logic                 lb_we;
  logic [LBW-1:0]       lb_addr;
  logic signed [DW-1:0] lb_wdata;

  logic signed [DW-1:0] pix;
  logic                 accept;
  logic                 in_pool_area;

  // Pixel value that enters pooling: raw, or clamped at zero when ReLU is fused.
  always_comb begin
`ifdef MAXPOOL_RELU_EN
    pix = bus.in_data[DW-1] ? '0 : bus.in_data;
`else
    pix = bus.in_data;
`endif
  end

  assign accept       = (state_q == S_RUN) && bus.in_valid && !bus.start;
  assign in_pool_area = (col_q < COL_POOL) && (row_q < ROW_POOL);
  assign lb_addr      = LBW'(col_q >> 1);

  // Next-state and datapath: frame control, raster counters, window pooling.
  always_comb begin
    // NOTE: every signal is given a default before any branch. A path that
    // leaves a signal unassigned would otherwise infer a latch.
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    pool_cnt_d  = pool_cnt_q;
    done_d      = done_q;
    lb_we       = 1'b0;
    lb_wdata    = smax(hold_q, pix);

    if (bus.start) begin
      // Re-arm from any state. Any partial windows are dropped: the line
      // buffer and hold are always rewritten before the new frame reads them.
      state_d     = S_RUN;
      col_d       = '0;
      row_d       = '0;
      out_index_d = '0;
      pool_cnt_d  = '0;
      done_d      = 1'b0;
    end else if (accept) begin
      if (in_pool_area) begin
        if (!col_q[0]) begin
          hold_d = pix;
        end else if (!row_q[0]) begin
          lb_we = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = smax(linebuf_q[lb_addr], smax(hold_q, pix));
          out_index_d = pool_cnt_q;
          pool_cnt_d  = pool_cnt_q + IW'(1);
        end
      end

      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all flops
    // sample their inputs from the same edge.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers: counters, hold, and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      pool_cnt_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      pool_cnt_q  <= pool_cnt_d;
      done_q      <= done_d;
    end
  end

  // Half-row line buffer holding the top-pair maxima of the current window row.
  always_ff @(posedge clk) begin
    // NOTE: the line buffer has no reset. Each entry is written on an even
    // row before it is read on the odd row, so its contents after reset
    // never reach the output.
    if (lb_we) linebuf_q[lb_addr] <= lb_wdata;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;
  assign bus.done      = done_q;

endmodule
